// File: rtl/ppu_sched_if.sv
// Scheduler bus: job control, tile credits, accumulator read port and PPU control.
interface ppu_sched_if #(
  parameter int ADDR_W = 4,
  parameter int DW     = 16
);
  logic              i_start;
  logic [1:0]        i_mode;
  logic              i_relu_en;
  logic              i_tile_rdy;
  logic              o_acc_re;
  logic [ADDR_W-1:0] o_acc_addr;
  logic [DW-1:0]     i_acc_data;
  logic              o_ppu_start;
  logic [DW-1:0]     o_ppu_acc_data;
  logic [1:0]        o_ppu_mode;
  logic              o_ppu_relu_en;
  logic              i_ppu_finish;
  logic              o_busy;
  logic              o_pass;
  logic              o_done;

  // Scheduler side.
  modport master (
    input  i_start, i_mode, i_relu_en, i_tile_rdy, i_acc_data, i_ppu_finish,
    output o_acc_re, o_acc_addr, o_ppu_start, o_ppu_acc_data, o_ppu_mode,
           o_ppu_relu_en, o_busy, o_pass, o_done
  );

  // Environment side (accumulator buffer, array, PPU, job source).
  modport slave (
    output i_start, i_mode, i_relu_en, i_tile_rdy, i_acc_data, i_ppu_finish,
    input  o_acc_re, o_acc_addr, o_ppu_start, o_ppu_acc_data, o_ppu_mode,
           o_ppu_relu_en, o_busy, o_pass, o_done
  );
endinterface

// File: rtl/ppu_sched.sv
// Tile scheduler: streams accumulator tiles to the PPU, one start pulse then
// AD rows per tile; one pass for INT4_VSQ, max-scan + calc passes otherwise.
module ppu_sched #(
  parameter int          AD       = 4,
  parameter int          TILE     = 3,
  parameter int          ADDR_W   = 4,
  parameter int          DW       = 16,
  parameter logic [1:0]  INT4_VSQ = 2'd3
) (
  input logic        i_clk,
  input logic        i_rst_n,
  ppu_sched_if.master sif
);
  localparam int CW = $clog2(TILE + 1);
  localparam int TW = $clog2(TILE + 1);
  localparam int RW = $clog2(AD + 1);

  typedef enum logic [2:0] {IDLE, WAIT, ISSUE, GAP, DRAIN} state_t;

  state_t            state;
  logic [RW-1:0]     row_cnt;    // next row to address while in ISSUE
  logic [TW-1:0]     tile_cnt;
  logic [ADDR_W-1:0] tile_base;  // tile_cnt*AD, kept incrementally
  logic [CW-1:0]     credit;
  logic              acc_re, ppu_start, relu, busy, pass, done;
  logic [ADDR_W-1:0] acc_addr;
  logic [1:0]        mode;
  logic [DW-1:0]     pass_data;
  logic              cred_inc, cred_dec;

  // Credits arrive from the array in any busy state; a pass-0 start spends one.
  assign cred_inc = sif.i_tile_rdy && (state != IDLE);
  assign cred_dec = ppu_start && !pass;

  // Job sequencer; every control output is a register loaded on the transition.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      row_cnt   <= '0;
      tile_cnt  <= '0;
      tile_base <= '0;
      acc_re    <= 1'b0;
      acc_addr  <= '0;
      ppu_start <= 1'b0;
      mode      <= '0;
      relu      <= 1'b0;
      busy      <= 1'b0;
      pass      <= 1'b0;
      done      <= 1'b0;
    end else begin
      ppu_start <= 1'b0;
      acc_re    <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: if (sif.i_start) begin
          mode      <= sif.i_mode;
          relu      <= sif.i_relu_en;
          tile_cnt  <= '0;
          tile_base <= '0;
          row_cnt   <= '0;
          pass      <= 1'b0;
          busy      <= 1'b1;
          state     <= WAIT;
        end
        // Calc pass re-reads resident tiles, so it never waits on credit.
        WAIT: if (pass || credit != '0) begin
          ppu_start <= 1'b1;
          acc_re    <= 1'b1;
          acc_addr  <= tile_base;
          row_cnt   <= RW'(1);
          state     <= ISSUE;
        end
        ISSUE: begin
          if (row_cnt == RW'(AD)) begin
            state <= GAP;
          end else begin
            acc_re   <= 1'b1;
            acc_addr <= tile_base + ADDR_W'(row_cnt);
            row_cnt  <= row_cnt + 1'b1;
          end
        end
        // One dead cycle lets the PPU fall back to its idle state.
        GAP: begin
          if (tile_cnt != TW'(TILE - 1)) begin
            tile_cnt  <= tile_cnt + 1'b1;
            tile_base <= tile_base + ADDR_W'(AD);
            state     <= WAIT;
          end else if (mode != INT4_VSQ && !pass) begin
            pass      <= 1'b1;
            tile_cnt  <= '0;
            tile_base <= '0;
            state     <= WAIT;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: if (sif.i_ppu_finish) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tile credit counter, saturating at TILE; rdy and consume together cancel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      credit <= '0;
    else if (state == IDLE && sif.i_start)
      credit <= '0;
    else if (cred_inc && !cred_dec && credit != CW'(TILE))
      credit <= credit + 1'b1;
    else if (cred_dec && !cred_inc)
      credit <= credit - 1'b1;
  end

  assign pass_data          = sif.i_acc_data;
  assign sif.o_ppu_acc_data = pass_data;
  assign sif.o_acc_re       = acc_re;
  assign sif.o_acc_addr     = acc_addr;
  assign sif.o_ppu_start    = ppu_start;
  assign sif.o_ppu_mode     = mode;
  assign sif.o_ppu_relu_en  = relu;
  assign sif.o_busy         = busy;
  assign sif.o_pass         = pass;
  assign sif.o_done         = done;
endmodule

// File: tb/tb_ppu_sched.sv
// Scoreboarded bench for ppu_sched: expected row reads are queued per job and
// retired by a negedge monitor; a credit model guards against credit-less issue.
module tb_ppu_sched;
  localparam int         AD = 4, TILE = 3, ADDR_W = 4, DW = 16;
  localparam logic [1:0] VSQ = 2'd3;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;

  ppu_sched_if #(.ADDR_W(ADDR_W), .DW(DW)) bus();
  ppu_sched #(.AD(AD), .TILE(TILE), .ADDR_W(ADDR_W), .DW(DW), .INT4_VSQ(VSQ))
    dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .sif(bus));

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              start;
    logic              pass;
  } exp_t;

  exp_t              sb[$];
  int                start_cyc[$];
  int                vec = 0, errs = 0, cyc = 0, last_start = -1, mcred = 0;
  logic              prev_re = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  exp_t              mon_e, mon_got;
  logic [DW-1:0]     mon_d;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Accumulator buffer model: 1-cycle read latency, data tagged with address.
  always @(posedge i_clk) bus.i_acc_data <= {8'hA5, 4'h0, bus.o_acc_addr};

  // Reference credit: counts rdy while a job is live, spent by pass-0 starts.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mcred <= 0;
    else if (bus.i_start && !bus.o_busy) mcred <= 0;
    else if (bus.i_tile_rdy && bus.o_busy && !(bus.o_ppu_start && !bus.o_pass))
      mcred <= (mcred < TILE) ? mcred + 1 : TILE;
    else if (!(bus.i_tile_rdy && bus.o_busy) && bus.o_ppu_start && !bus.o_pass)
      mcred <= mcred - 1;
  end

  // Monitor: retire expected reads, check data pass-through, start rules.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      prev_re = 1'b0;
    end else begin
      if (prev_re) begin
        vec++;
        mon_d = {8'hA5, 4'h0, prev_addr};
        if (bus.o_ppu_acc_data !== mon_d) begin
          errs++;
          $display("FAIL acc_data: got %h want %h", bus.o_ppu_acc_data, mon_d);
        end
      end
      prev_re   = bus.o_acc_re;
      prev_addr = bus.o_acc_addr;
      if (bus.o_acc_re) begin
        vec++;
        mon_got = '{addr: bus.o_acc_addr, start: bus.o_ppu_start, pass: bus.o_pass};
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL read_unexpected: addr %0d start %b pass %b, want no read",
                   mon_got.addr, mon_got.start, mon_got.pass);
        end else begin
          mon_e = sb.pop_front();
          if (mon_got !== mon_e) begin
            errs++;
            $display("FAIL read_seq: got addr %0d start %b pass %b want addr %0d start %b pass %b",
                     mon_got.addr, mon_got.start, mon_got.pass, mon_e.addr, mon_e.start, mon_e.pass);
          end
        end
      end
      if (bus.o_ppu_start) begin
        vec++;
        if (!bus.o_acc_re || (!bus.o_pass && mcred == 0) ||
            (last_start >= 0 && cyc - last_start < AD + 2)) begin
          errs++;
          $display("FAIL start_rule: re %b pass %b credit %0d spacing %0d, want re 1, credit>0, spacing>=%0d",
                   bus.o_acc_re, bus.o_pass, mcred, cyc - last_start, AD + 2);
        end
        start_cyc.push_back(cyc);
        last_start = cyc;
      end
    end
  end

  function automatic logic [ADDR_W+7:0] outs();
    return {bus.o_acc_re, bus.o_acc_addr, bus.o_ppu_start, bus.o_ppu_mode,
            bus.o_ppu_relu_en, bus.o_busy, bus.o_pass, bus.o_done};
  endfunction

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic rdy(input int n);
    bus.i_tile_rdy = 1'b1;
    repeat (n) tick();
    bus.i_tile_rdy = 1'b0;
  endtask

  task automatic push_job(input logic [1:0] m);
    exp_t e;
    for (int p = 0; p < ((m == VSQ) ? 1 : 2); p++)
      for (int t = 0; t < TILE; t++)
        for (int r = 0; r < AD; r++) begin
          e.addr  = ADDR_W'(t * AD + r);
          e.start = (r == 0);
          e.pass  = p[0];
          sb.push_back(e);
        end
  endtask

  task automatic start_job(input logic [1:0] m, input logic relu);
    bus.i_start = 1'b1; bus.i_mode = m; bus.i_relu_en = relu;
    push_job(m);
    start_cyc.delete();
    last_start = -1;
    tick();
    bus.i_start = 1'b0;
    vec++;
    if ({bus.o_busy, bus.o_ppu_start, bus.o_ppu_mode, bus.o_ppu_relu_en} !== {2'b10, m, relu}) begin
      errs++;
      $display("FAIL job_accept: busy/start/mode/relu %b%b %b %b want 10 %b %b",
               bus.o_busy, bus.o_ppu_start, bus.o_ppu_mode, bus.o_ppu_relu_en, m, relu);
    end
  endtask

  task automatic finish_job(input string nm);
    int n = 0;
    logic d1, b1;
    while (sb.size() != 0 && n < 400) begin tick(); n++; end
    vec++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL %s_reads: %0d reads outstanding, want 0", nm, sb.size());
      sb.delete();
    end
    repeat (3) tick();
    bus.i_ppu_finish = 1'b1;
    tick();
    bus.i_ppu_finish = 1'b0;
    d1 = bus.o_done; b1 = bus.o_busy;
    tick();
    vec++;
    if ({d1, b1, bus.o_done} !== 3'b100) begin
      errs++;
      $display("FAIL %s_done: done/busy/next_done %b%b%b want 100", nm, d1, b1, bus.o_done);
    end
  endtask

  task automatic check_spacing(input string nm, input int n);
    logic ok = (start_cyc.size() == n);
    for (int i = 1; ok && i < n; i++) ok = (start_cyc[i] - start_cyc[i-1] == AD + 2);
    vec++;
    if (!ok) begin
      errs++;
      $display("FAIL %s_starts: %0d starts (first gap %0d) want %0d starts %0d apart", nm,
               start_cyc.size(), (start_cyc.size() > 1) ? start_cyc[1] - start_cyc[0] : 0, n, AD + 2);
    end
  endtask

  task automatic check_credit(input string nm, input int want);
    vec++;
    if (int'(dut.credit) !== want || mcred !== want) begin
      errs++;
      $display("FAIL %s_credit: got %0d (model %0d) want %0d", nm, dut.credit, mcred, want);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    vec++;
    if (outs() !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got %b want all zero", outs());
    end
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_vsq();
    start_job(VSQ, 1'b1);
    rdy(3);
    finish_job("vsq");
    check_spacing("vsq", 3);
    check_credit("vsq_end", 0);
  endtask

  task automatic test_two_pass();
    start_job(2'd1, 1'b0);
    rdy(3);
    finish_job("two_pass");
    check_spacing("two_pass", 6);
  endtask

  task automatic test_trickle();
    int rc[3];
    logic ok = 1'b1;
    start_job(VSQ, 1'b0);
    for (int i = 0; i < 3; i++) begin
      repeat (20) tick();
      rc[i] = cyc;
      rdy(1);
    end
    finish_job("trickle");
    vec++;
    if (start_cyc.size() != 3) ok = 1'b0;
    for (int i = 0; ok && i < 3; i++) ok = (start_cyc[i] >= rc[i] + 2) && (start_cyc[i] < rc[i] + 20);
    if (!ok) begin
      errs++;
      $display("FAIL trickle_order: %0d starts, first at %0d vs credit at %0d", start_cyc.size(),
               (start_cyc.size() > 0) ? start_cyc[0] : -1, rc[0]);
    end
    check_credit("trickle_end", 0);
  endtask

  task automatic test_credit();
    int n = 0;
    // rdy coinciding with the consuming start leaves credit unchanged.
    start_job(VSQ, 1'b0);
    rdy(1);
    while (!bus.o_ppu_start && n < 50) begin tick(); n++; end
    check_credit("same_cycle_pre", 1);
    rdy(1);
    check_credit("same_cycle_post", 1);
    repeat (8) tick();
    rdy(1);
    finish_job("same_cycle");
    check_credit("same_cycle_end", 0);
    // Pass 1 consumes nothing, so extra credits saturate at TILE.
    start_job(2'd0, 1'b0);
    rdy(3);
    n = 0;
    while (!bus.o_pass && n < 200) begin tick(); n++; end
    rdy(4);
    check_credit("saturate", TILE);
    finish_job("saturate");
  endtask

  task automatic test_busy_ignore();
    int n = 0;
    logic [3:0] s;
    start_job(VSQ, 1'b1);
    check_credit("start_clears", 0);
    rdy(3);
    while (!bus.o_acc_re && n < 50) begin tick(); n++; end
    bus.i_start = 1'b1; bus.i_mode = 2'd1; bus.i_relu_en = 1'b0; bus.i_ppu_finish = 1'b1;
    tick();
    bus.i_start = 1'b0; bus.i_ppu_finish = 1'b0;
    s = {bus.o_ppu_mode, bus.o_ppu_relu_en, bus.o_done};
    tick();
    vec++;
    if ({s, bus.o_done, bus.o_busy} !== {VSQ, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      errs++;
      $display("FAIL busy_ignore: mode/relu/done %b next_done %b busy %b want %b100 1",
               s, bus.o_done, bus.o_busy, VSQ);
    end
    finish_job("busy_ignore");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    start_job(2'd1, 1'b0);
    rdy(3);
    while (start_cyc.size() < 2 && n < 100) begin tick(); n++; end
    tick();
    i_rst_n = 1'b0;
    #1;
    vec++;
    if (outs() !== '0) begin
      errs++;
      $display("FAIL reset_mid: got %b want all zero", outs());
    end
    sb.delete();
    tick(); tick();
    i_rst_n = 1'b1;
    tick();
    start_job(VSQ, 1'b0);
    repeat (8) tick();
    vec++;
    if (sb.size() != AD * TILE || int'(dut.credit) != 0) begin
      errs++;
      $display("FAIL reset_restart_idle: %0d reads pending credit %0d want %0d and 0",
               sb.size(), dut.credit, AD * TILE);
    end
    rdy(3);
    finish_job("after_reset");
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_mode = '0; bus.i_relu_en = 1'b0;
    bus.i_tile_rdy = 1'b0; bus.i_ppu_finish = 1'b0;
    test_reset();
    test_vsq();
    test_two_pass();
    test_trickle();
    test_credit();
    test_busy_ignore();
    test_reset_mid();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
